// File: rtl/lab2_proc_shared_mul_unit_if.sv
// Request/response bundle for the shared multiplier.
// master: the requester side (X-stage issue, debug port, testbench).
// slave:  the multiplier unit.
interface lab2_proc_shared_mul_unit_if #(
  parameter int p_nbits = 32
);
  logic                   req0_val;
  logic                   req0_rdy;
  logic [2*p_nbits-1:0]   req0_msg;
  logic                   req1_val;
  logic                   req1_rdy;
  logic [2*p_nbits-1:0]   req1_msg;
  logic                   resp0_val;
  logic                   resp0_rdy;
  logic [p_nbits-1:0]     resp0_msg;
  logic                   resp1_val;
  logic                   resp1_rdy;
  logic [p_nbits-1:0]     resp1_msg;

  modport master (
    output req0_val, req0_msg, req1_val, req1_msg, resp0_rdy, resp1_rdy,
    input  req0_rdy, req1_rdy, resp0_val, resp0_msg, resp1_val, resp1_msg
  );

  modport slave (
    input  req0_val, req0_msg, req1_val, req1_msg, resp0_rdy, resp1_rdy,
    output req0_rdy, req1_rdy, resp0_val, resp0_msg, resp1_val, resp1_msg
  );
endinterface

// File: rtl/lab2_proc_shared_mul_unit.sv
// Iterative shift-add multiplier shared by two val/rdy requesters through a
// round-robin arbiter. Returns the low p_nbits of a*b to the granted requester.
// Optional macro LAB2_PROC_MUL_EARLY_EXIT_EN: leave CALC as soon as the
// remaining multiplier bits are all zero (same result, shorter latency).
//
// state | meaning
// IDLE  | arbitrating, accepting one request
// CALC  | one shift-add step per cycle
// DONE  | result presented to the owner until it is taken
module lab2_proc_shared_mul_unit #(
  parameter int p_nbits = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  lab2_proc_shared_mul_unit_if.slave   mul
);

  localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
  localparam logic [CW-1:0] LAST = CW'(p_nbits - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [p_nbits-1:0] a_reg;
  logic [p_nbits-1:0] b_reg;
  logic [p_nbits-1:0] result_reg;
  logic [CW-1:0]      counter;
  logic               owner;
  logic               prio;

  logic               grant;
  logic               req_fire;
  logic               resp_fire;
  logic               calc_last;
  logic [p_nbits-1:0] b_next;
  logic [p_nbits-1:0] a_in;
  logic [p_nbits-1:0] b_in;

  // Round-robin grant: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant = 1'b0;
    if (mul.req0_val && mul.req1_val) grant = prio;
    else if (mul.req1_val)            grant = 1'b1;
    else                              grant = 1'b0;
  end

  // Handshake outputs are forced low while reset is asserted, since the
  // state register only clears on the following edge.
  always_comb begin
    mul.req0_rdy  = !reset && (state == IDLE) && mul.req0_val && !grant;
    mul.req1_rdy  = !reset && (state == IDLE) && mul.req1_val &&  grant;
    mul.resp0_val = !reset && (state == DONE) && !owner;
    mul.resp1_val = !reset && (state == DONE) &&  owner;
    mul.resp0_msg = mul.resp0_val ? result_reg : '0;
    mul.resp1_msg = mul.resp1_val ? result_reg : '0;
  end

  // Operand selection, fire detection and CALC exit condition.
  always_comb begin
    a_in      = grant ? mul.req1_msg[2*p_nbits-1:p_nbits] : mul.req0_msg[2*p_nbits-1:p_nbits];
    b_in      = grant ? mul.req1_msg[p_nbits-1:0]         : mul.req0_msg[p_nbits-1:0];
    req_fire  = mul.req0_rdy || mul.req1_rdy;
    resp_fire = (state == DONE) && (owner ? mul.resp1_rdy : mul.resp0_rdy);
    b_next    = b_reg >> 1;
`ifdef LAB2_PROC_MUL_EARLY_EXIT_EN
    calc_last = (counter == LAST) || (b_next == '0);
`else
    calc_last = (counter == LAST);
`endif
  end

  // Sequencer: accept, shift-add for up to p_nbits cycles, hold result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      counter    <= '0;
      owner      <= 1'b0;
      prio       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            a_reg      <= a_in;
            b_reg      <= b_in;
            result_reg <= '0;
            counter    <= '0;
            owner      <= grant;
            state      <= CALC;
          end
        end
        CALC: begin
          if (b_reg[0]) result_reg <= result_reg + a_reg;
          a_reg   <= a_reg << 1;
          b_reg   <= b_next;
          counter <= counter + CW'(1);
          if (calc_last) state <= DONE;
        end
        DONE: begin
          if (resp_fire) begin
            prio  <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_proc_shared_mul_unit.sv
// Directed bench for the shared multiplier with a response scoreboard.
module tb_lab2_proc_shared_mul_unit;
  localparam int N = 32;

  typedef struct packed {
    logic          port;
    logic [N-1:0]  val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   failed = 0;
  exp_t sb[$];

  lab2_proc_shared_mul_unit_if #(.p_nbits(N)) mif ();
  lab2_proc_shared_mul_unit #(.p_nbits(N)) dut (.clk(clk), .reset(reset), .mul(mif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int exp_lat(input logic [N-1:0] b);
    int n;
    n = N;
`ifdef LAB2_PROC_MUL_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < N; i++) if (b[i]) n = i + 1;
`endif
    return n + 1;
  endfunction

  task automatic drive_req(input bit port, input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    if (port) begin mif.req1_val = v; mif.req1_msg = {a, b}; end
    else      begin mif.req0_val = v; mif.req0_msg = {a, b}; end
  endtask

  task automatic send(input bit port, input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit push, output int t);
    bit got;
    logic [N-1:0] p;
    exp_t e;
    got = 0;
    drive_req(port, 1'b1, a, b);
    settle();
    for (int i = 0; i < 60 && !got; i++) begin
      if ((port ? mif.req1_rdy : mif.req0_rdy) === 1'b1) got = 1;
      else begin tick(); settle(); end
    end
    t = cyc;
    chk("req_accept", got, 1);
    if (got && push) begin
      p = a * b;
      e.port = port;
      e.val = p;
      sb.push_back(e);
    end
    tick();
    if (port) mif.req1_val = 1'b0; else mif.req0_val = 1'b0;
  endtask

  task automatic wait_resp(input bit port, input int t, input int lat, input int hold);
    bit got;
    bit other_hi;
    exp_t e;
    logic [N-1:0] exp_msg;
    got = 0;
    other_hi = 0;
    exp_msg = '0;
    mif.resp0_rdy = 1'b0;
    mif.resp1_rdy = 1'b0;
    settle();
    for (int i = 0; i < 120 && !got; i++) begin
      if ((port ? mif.resp0_val : mif.resp1_val) !== 1'b0) other_hi = 1;
      if ((port ? mif.resp1_val : mif.resp0_val) === 1'b1) got = 1;
      else begin tick(); settle(); end
    end
    chk("resp_arrive", got, 1);
    chk("other_resp_quiet", other_hi, 0);
    if (!got) return;
    chk("latency", cyc - t, lat);
    if (sb.size() == 0) chk("sb_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      exp_msg = e.val;
      chk("resp_port", port, e.port);
      chk("resp_msg", port ? mif.resp1_msg : mif.resp0_msg, exp_msg);
    end
    for (int i = 0; i < hold; i++) begin
      tick(); settle();
      chk("hold_val", port ? mif.resp1_val : mif.resp0_val, 1);
      chk("hold_msg", port ? mif.resp1_msg : mif.resp0_msg, exp_msg);
      chk("hold_req_rdy", {mif.req0_rdy, mif.req1_rdy}, 0);
    end
    if (port) mif.resp1_rdy = 1'b1; else mif.resp0_rdy = 1'b1;
    tick();
    mif.resp0_rdy = 1'b0;
    mif.resp1_rdy = 1'b0;
    settle();
    chk("back_to_idle", {mif.resp0_val, mif.resp1_val}, 0);
  endtask

  initial begin
    int t;
    bit seen;
    reset = 1'b1;
    mif.req0_val = 1'b0; mif.req0_msg = '0;
    mif.req1_val = 1'b0; mif.req1_msg = '0;
    mif.resp0_rdy = 1'b0; mif.resp1_rdy = 1'b0;

    // reset: no rdy even with a valid request, no responses, zero msgs
    drive_req(0, 1'b1, 32'd1, 32'd1);
    tick(); tick(); settle();
    chk("rst_req0_rdy", mif.req0_rdy, 0);
    chk("rst_resp_val", {mif.resp0_val, mif.resp1_val}, 0);
    chk("rst_resp_msg", {mif.resp0_msg, mif.resp1_msg}, 0);
    mif.req0_val = 1'b0;
    reset = 1'b0;
    tick(); settle();
    chk("post_rst_resp_msg", {mif.resp0_msg, mif.resp1_msg}, 0);

    // basic
    send(0, 32'd3, 32'd4, 1, t);
    wait_resp(0, t, exp_lat(32'd4), 0);

    // wrap / sign
    send(1, 32'hFFFF_FFFF, 32'd5, 1, t);
    wait_resp(1, t, exp_lat(32'd5), 0);
    send(1, 32'h8000_0000, 32'd2, 1, t);
    wait_resp(1, t, exp_lat(32'd2), 0);

    // contention: prio is 0 here after req1 was served last
    drive_req(0, 1'b1, 32'd2, 32'd3);
    drive_req(1, 1'b1, 32'd4, 32'd5);
    settle();
    chk("cont_grant0_rdy0", mif.req0_rdy, 1);
    chk("cont_grant0_rdy1", mif.req1_rdy, 0);
    send(0, 32'd2, 32'd3, 1, t);
    wait_resp(0, t, exp_lat(32'd3), 0);
    drive_req(0, 1'b1, 32'd2, 32'd3);
    settle();
    chk("cont_grant1_rdy1", mif.req1_rdy, 1);
    chk("cont_grant1_rdy0", mif.req0_rdy, 0);
    send(1, 32'd4, 32'd5, 1, t);
    wait_resp(1, t, exp_lat(32'd5), 0);
    settle();
    chk("cont_grant2_rdy0", mif.req0_rdy, 1);
    chk("cont_grant2_rdy1", mif.req1_rdy, 0);
    send(0, 32'd2, 32'd3, 1, t);
    wait_resp(0, t, exp_lat(32'd3), 0);

    // backpressure with req1 waiting; prio flips to 1 afterwards
    send(0, 32'd7, 32'd6, 1, t);
    drive_req(1, 1'b1, 32'd1, 32'd1);
    wait_resp(0, t, exp_lat(32'd6), 5);
    chk("bp_next_grant1", mif.req1_rdy, 1);
    mif.req1_val = 1'b0;

    // reset mid-CALC: transaction dropped, prio back to 0
    send(0, 32'd9, 32'd9, 0, t);
    repeat (9) tick();
    reset = 1'b1;
    drive_req(1, 1'b1, 32'd1, 32'd1);
    settle();
    chk("midrst_req1_rdy", mif.req1_rdy, 0);
    chk("midrst_resp_val", {mif.resp0_val, mif.resp1_val}, 0);
    tick();
    reset = 1'b0;
    mif.req1_val = 1'b0;
    mif.resp0_rdy = 1'b1;
    mif.resp1_rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (mif.resp0_val !== 1'b0 || mif.resp1_val !== 1'b0) seen = 1;
      tick();
    end
    mif.resp0_rdy = 1'b0;
    mif.resp1_rdy = 1'b0;
    chk("midrst_no_resp", seen, 0);
    drive_req(0, 1'b1, 32'd3, 32'd3);
    drive_req(1, 1'b1, 32'd2, 32'd2);
    settle();
    chk("prio_reset_rdy0", mif.req0_rdy, 1);
    chk("prio_reset_rdy1", mif.req1_rdy, 0);
    mif.req0_val = 1'b0;
    send(1, 32'd2, 32'd2, 1, t);
    wait_resp(1, t, exp_lat(32'd2), 0);

    // early-exit shaped operands (full latency when the macro is off)
    send(0, 32'd7, 32'd2, 1, t);
    wait_resp(0, t, exp_lat(32'd2), 0);
    send(0, 32'd5, 32'd0, 1, t);
    wait_resp(0, t, exp_lat(32'd0), 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lab2_proc_shared_mul_unit.md
Name: lab2_proc_shared_mul_unit

Overview:
- Iterative shift-add multiplier shared between two requesters (e.g. X-stage MUL issue and a debug/test port) through a round-robin arbiter.
- Sequences the multiply over p_nbits cycles and returns the low p_nbits of the product to the granted requester.
- Replaces the single-cycle `*` path of the ALU for MUL; sits beside the ALU in the X stage.
- All handshakes are val/rdy latency-insensitive.

Parameters:
- p_nbits, 32, operand and result width; also the maximum number of CALC cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req0_val  input  1  requester 0 has a valid operand pair
- req0_rdy  output  1  unit accepts requester 0 this cycle
- req0_msg  input  2*p_nbits  {a[2n-1:n], b[n-1:0]}
- req1_val  input  1  requester 1 valid
- req1_rdy  output  1  unit accepts requester 1 this cycle
- req1_msg  input  2*p_nbits  {a, b}
- resp0_val  output  1  result valid for requester 0
- resp0_rdy  input  1  requester 0 takes the result
- resp0_msg  output  p_nbits  product, low p_nbits
- resp1_val  output  1  result valid for requester 1
- resp1_rdy  input  1  requester 1 takes the result
- resp1_msg  output  p_nbits  product, low p_nbits

Behaviour:
- State: fsm ∈ {IDLE, CALC, DONE}; registers a_reg, b_reg, result_reg (p_nbits each); counter (clog2(p_nbits) bits); owner (1 bit); prio (1 bit, the requester favoured next).
- Reset values: fsm=IDLE, result_reg=0, counter=0, owner=0, prio=0.
- All rdy and val outputs are 0 during and after reset until the next IDLE evaluation.
- resp*_msg is 0 out of reset.
- IDLE, arbitration (combinational):
  - Only req0_val: grant 0.
  - Only req1_val: grant 1.
  - Both valid: grant prio.
  - reqX_rdy=1 only for the granted requester. Never both rdy; never rdy outside IDLE.
- IDLE, on fire (val&rdy): a_reg=a, b_reg=b, result_reg=0, counter=0, owner=grant; go to CALC.
- CALC, each cycle:
  - If b_reg[0], then result_reg += a_reg (mod 2^p_nbits).
  - a_reg <<= 1; b_reg >>= 1; counter++.
  - After the cycle where counter == p_nbits-1, go to DONE.
- DONE:
  - resp[owner]_val=1 and resp[owner]_msg=result_reg. The other response val stays 0.
  - msg stays stable while val is high and rdy is low.
  - On resp fire: go to IDLE and set prio = ~owner.
  - No request is accepted in the DONE cycle.
- Latency: request fires in cycle T → CALC in T+1..T+p_nbits → resp_val first high in T+p_nbits+1.
- Throughput: at most one multiply per p_nbits+2 cycles.
- Arithmetic: result equals low p_nbits of a*b. It is identical for signed and unsigned operands (two's complement).
- A requester that holds val while the other is granted keeps its msg; it is guaranteed service next, because prio flips.
- Reset mid-operation (CALC or DONE): the transaction is dropped, no response is issued, and all state returns to reset values in the next cycle.
- Output values for the non-owner response port are don't-care but must be driven to 0.

Optional Feature:
- Macro: LAB2_PROC_MUL_EARLY_EXIT_EN
- Defined: in CALC, also go to DONE after any cycle whose shifted b_reg (next value) is 0. Minimum is 1 CALC cycle (b=0 or b=1).
- Not defined: always exactly p_nbits CALC cycles.
- Result values are identical in both builds; only latency differs.

Test Plan:
- Basic: req0 sends a=3, b=4 at cycle T, resp0_rdy=1 → resp0_val first high at T+33 with msg=12; resp1_val stays 0 throughout.
- Wrap/sign: req1 sends a=0xFFFFFFFF, b=5 → resp1_msg=0xFFFFFFFB. Then a=0x80000000, b=2 → 0x00000000.
- Contention: req0 (2×3) and req1 (4×5) both valid from cycle 0 → req0 served first (resp0_msg=6). Next IDLE grants req1 (resp1_msg=20). If both are valid again, req0 is granted after that.
- Backpressure: 7×6 on req0 with resp0_rdy=0 for 5 cycles after resp0_val rises → val and msg=42 held stable. req0_rdy and req1_rdy stay 0. Release → IDLE one cycle later.
- Reset mid-CALC: fire 9×9, assert reset 10 cycles later for 1 cycle → no resp*_val ever rises for it. The next request 2×2 on req1 gives resp=4 with full latency; prio was reset to 0.
- Early exit: 7×2 → with LAB2_PROC_MUL_EARLY_EXIT_EN, resp at T+3 (2 CALC cycles); without it, T+33. Both give msg=14. Also 5×0 gives 0 at T+2 with the macro.
